// File: rtl/param_regfile.sv
// Parameterised two-read/one-write register file with a handshaked full-content
// dump engine that scans every register in address order.
module param_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} dumpState_t;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wrEn;
  dumpState_t        state, nextState;
  logic [ADDR_W-1:0] idx, nextIdx;

  // rst_n gates the write so neither storage nor the bypass path sees we during reset
  assign wrEn = we && rst_n && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrEn) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [DATA_W-1:0] readReg(input logic [ADDR_W-1:0] a);
    if ((ZERO_REG != 0) && (a == '0)) return '0;
    if ((BYPASS != 0) && wrEn && (a == wr_addr)) return wr_data;
    return regs[a];
  endfunction

  always_comb begin
    rd_data1 = readReg(rd_addr1);
    rd_data2 = readReg(rd_addr2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
    end
  end

  always_comb begin
    nextState  = state;
    nextIdx    = idx;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          nextState = SCAN;
          nextIdx   = '0;
        end
      end
      SCAN: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        dump_addr  = idx;
        dump_data  = readReg(idx);
        if (dump_ready) begin
          if (idx == '1) nextState = DONE;
          else           nextIdx   = idx + 1'b1;
        end
      end
      DONE: begin
        dump_done = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_param_regfile.sv
// Scoreboard bench for param_regfile: default instance plus a BYPASS=0/ZERO_REG=0
// instance sharing the same stimulus.
module tb_param_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [31:0] wr_data;
  logic        we, dump_start, dump_ready;

  logic [31:0] rd_data1, rd_data2, dump_data;
  logic        dump_busy, dump_valid, dump_done;
  logic [4:0]  dump_addr;

  logic [31:0] bRd1, bRd2, bDumpData;
  logic        bBusy, bValid, bDone;
  logic [4:0]  bDumpAddr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mA [32];
  logic [31:0] mB [32];
  logic [36:0] expQ [$];

  always #5 clk = ~clk;

  param_regfile dutA (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .dump_start(dump_start), .dump_busy(dump_busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done)
  );

  param_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(bRd1), .rd_data2(bRd2), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .dump_start(dump_start), .dump_busy(bBusy),
    .dump_valid(bValid), .dump_ready(dump_ready), .dump_addr(bDumpAddr),
    .dump_data(bDumpData), .dump_done(bDone)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearModels();
    for (int i = 0; i < 32; i++) begin
      mA[i] = '0;
      mB[i] = '0;
    end
  endtask

  task automatic modelWrite(input int a, input logic [31:0] d);
    if (a != 0) mA[a] = d;
    mB[a] = d;
  endtask

  task automatic wrReg(input int a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    modelWrite(a, d);
  endtask

  task automatic rdCheck(input int a1, input int a2);
    @(negedge clk);
    we = 1'b0;
    rd_addr1 = 5'(a1);
    rd_addr2 = 5'(a2);
    #2;
    checkVal($sformatf("rdA1[%0d]", a1), rd_data1, mA[a1]);
    checkVal($sformatf("rdA2[%0d]", a2), rd_data2, mA[a2]);
    checkVal($sformatf("rdB1[%0d]", a1), bRd1, mB[a1]);
    checkVal($sformatf("rdB2[%0d]", a2), bRd2, mB[a2]);
  endtask

  // stallAt < 0: dump_ready toggles each cycle; otherwise ready stays high except a
  // two-cycle stall on stallAt, during which that register is rewritten with 0x1234.
  task automatic doDump(input int stallAt);
    int beats = 0;
    int dones = 0;
    int stallCnt = 0;
    bit finished = 0;
    logic [36:0] e;
    if (stallAt >= 0) modelWrite(stallAt, 32'h1234);
    expQ.delete();
    for (int i = 0; i < 32; i++) expQ.push_back({5'(i), mA[i]});
    @(negedge clk);
    we = 1'b0;
    dump_ready = 1'b0;
    dump_start = 1'b1;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      @(negedge clk);
      dump_start = (cyc == 3);
      if (stallAt < 0) begin
        dump_ready = cyc[0];
      end else if (dump_valid && dump_addr == 5'(stallAt) && stallCnt < 2) begin
        dump_ready = 1'b0;
        we = (stallCnt == 0);
        wr_addr = 5'(stallAt);
        wr_data = 32'h1234;
        stallCnt++;
      end else begin
        dump_ready = 1'b1;
        we = 1'b0;
      end
      #2;
      if (dump_done) begin
        dones++;
        checkVal("doneBusyValid", {30'd0, dump_busy, dump_valid}, 32'd0);
      end
      if (dump_valid && dump_ready) begin
        beats++;
        if (expQ.size() == 0) begin
          checkVal("extraBeat", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkVal("beatAddr", {27'd0, dump_addr}, {27'd0, e[36:32]});
          checkVal($sformatf("beatData[%0d]", e[36:32]), dump_data, e[31:0]);
        end
      end
      if (dones > 0 && !dump_done && !dump_busy) finished = 1;
    end
    we = 1'b0;
    dump_start = 1'b0;
    checkVal("dumpFinished", {31'd0, finished}, 32'd1);
    checkVal("doneCount", dones, 32'd1);
    checkVal("beatCount", beats, 32'd32);
    checkVal("queueLeft", expQ.size(), 32'd0);
  endtask

  initial begin
    bit found = 0;
    rst_n = 1'b0;
    we = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hAA;
    dump_start = 1'b1;
    dump_ready = 1'b0;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd0;
    clearModels();
    #3;
    checkVal("rstRd1", rd_data1, 32'd0);
    checkVal("rstDumpOut", {dump_addr, dump_busy, dump_valid, dump_done}, 32'd0);
    checkVal("rstDumpData", dump_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rstIgnoreWe", rd_data1, 32'd0);
    checkVal("rstIgnoreStart", {31'd0, dump_busy}, 32'd0);
    dump_start = 1'b0;
    rst_n = 1'b1;
    modelWrite(3, 32'hAA);
    #2;
    checkVal("firstWrBypass", rd_data1, 32'hAA);
    rdCheck(3, 0);

    // same-cycle write forwarding
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr1 = 5'd5;
    #2;
    checkVal("bypassOn", rd_data1, 32'hDEADBEEF);
    checkVal("bypassOff", bRd1, mB[5]);
    modelWrite(5, 32'hDEADBEEF);
    rdCheck(5, 3);

    // register 0 write
    @(negedge clk);
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rd_addr1 = 5'd0;
    #2;
    checkVal("zeroRegBypass", rd_data1, 32'd0);
    checkVal("noZeroPreWrite", bRd1, mB[0]);
    modelWrite(0, 32'hFFFFFFFF);
    rdCheck(0, 0);

    for (int i = 1; i <= 20; i++) wrReg(i, 32'(i));
    for (int p = 0; p < 9; p++) rdCheck(2 * p, 2 * p + 1);

    for (int i = 0; i < 32; i++) wrReg(i, 32'(i));
    rdCheck(0, 31);
    doDump(-1);
    doDump(7);
    rdCheck(7, 8);

    // reset in the middle of a dump
    @(negedge clk);
    dump_ready = 1'b1;
    dump_start = 1'b1;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      dump_start = 1'b0;
      if (dump_valid && dump_addr == 5'd10) found = 1;
    end
    checkVal("reachBeat10", {31'd0, found}, 32'd1);
    rd_addr1 = 5'd10;
    rd_addr2 = 5'd31;
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("abortOut", {dump_addr, dump_busy, dump_valid, dump_done}, 32'd0);
    checkVal("abortData", dump_data, 32'd0);
    checkVal("abortRd1", rd_data1, 32'd0);
    checkVal("abortRd2", rd_data2, 32'd0);
    checkVal("abortRdB", bRd2, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("abortNoDone", {31'd0, dump_done}, 32'd0);
    end
    rst_n = 1'b1;
    clearModels();
    doDump(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
